// File: rtl/gen_tick_frame.sv
// Tick/frame generator: divides rawclk by a programmable half-period and walks a
// neuron/slot counter, emitting single-cycle clock-enable strobes and a host handshake.
`timescale 1ns/1ps
module gen_tick_frame #(
  parameter int NN     = 8,
  parameter int SLOT_W = 2,
  parameter int NTAP   = 3,
  parameter int FCW    = 16
) (
  input  logic                     rawclk,
  input  logic                     reset_n,
  input  logic [31:0]              half_cnt,
  input  logic                     enable,
  input  logic                     mode,
  input  logic                     start,
  input  logic [NTAP*(NN+1)-1:0]   tap_idx,
  output logic                     clk_out,
  output logic                     tick,
  output logic [NN+SLOT_W:0]       neuron_cnt,
  output logic [NN:0]              neuron_idx,
  output logic                     frame_strobe,
  output logic [NTAP-1:0]          tap_strobe,
  output logic [FCW-1:0]           frame_cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = NN + SLOT_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_delay;
  logic             r_clk, r_tick, r_pend, r_oneshot, r_frame_strobe, r_done;
  logic [CW-1:0]    r_cnt;
  logic [NTAP-1:0]  r_tap;
  logic [FCW-1:0]   r_frames;

  logic             w_rise, w_fire, w_pend_nxt, w_oneshot_nxt, w_done_nxt;
  logic [CW-1:0]    w_cnt_nxt, w_eval_cnt;
  logic [FCW-1:0]   w_frames_nxt;
  logic [NTAP-1:0]  w_tap_hit;

  // The >= compare keeps a shrinking half_cnt from forcing a full 32-bit wrap.
  always_ff @(posedge rawclk or negedge reset_n) begin
    if (!reset_n) begin
      r_delay <= '0;
      r_clk   <= 1'b0;
    end else if (r_delay >= half_cnt) begin
      r_delay <= '0;
      r_clk   <= ~r_clk;
    end else begin
      r_delay <= r_delay + 32'd1;
    end
  end

  assign w_rise     = (r_delay >= half_cnt) && !r_clk;
  assign w_eval_cnt = (r_state == S_RUN) ? r_cnt : '0;

  always_comb begin
    w_tap_hit = '0;
    for (int i = 0; i < NTAP; i++) begin
      w_tap_hit[i] = (w_eval_cnt[CW-1:SLOT_W] == tap_idx[i*(NN+1) +: NN+1]) &&
                     (w_eval_cnt[SLOT_W-1:0] == '0);
    end
  end

  // The one-shot launch edge fires strobes for count 0 and jumps straight to 1.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_frames_nxt  = r_frames;
    w_pend_nxt    = r_pend;
    w_oneshot_nxt = r_oneshot;
    w_fire        = 1'b0;
    w_done_nxt    = 1'b0;
    if (start && (r_state == S_IDLE)) w_pend_nxt = 1'b1;
    if (w_rise) begin
      case (r_state)
        S_IDLE: begin
          if (!mode) begin
            if (enable) begin
              w_state_nxt   = S_RUN;
              w_oneshot_nxt = 1'b0;
            end
          end else if (r_pend) begin
            w_state_nxt   = S_RUN;
            w_oneshot_nxt = 1'b1;
            w_pend_nxt    = 1'b0;
            w_cnt_nxt     = CW'(1);
            w_fire        = 1'b1;
          end
        end
        S_RUN: begin
          w_fire    = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == '1) w_frames_nxt = r_frames + 1'b1;
          if (r_oneshot) begin
            if (r_cnt == '1) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else if (!enable) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rawclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_frames       <= '0;
      r_pend         <= 1'b0;
      r_oneshot      <= 1'b0;
      r_tick         <= 1'b0;
      r_frame_strobe <= 1'b0;
      r_tap          <= '0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_frames       <= w_frames_nxt;
      r_pend         <= w_pend_nxt;
      r_oneshot      <= w_oneshot_nxt;
      r_tick         <= w_rise;
      r_frame_strobe <= w_fire && (w_eval_cnt == '0);
      r_tap          <= w_fire ? w_tap_hit : '0;
      r_done         <= w_done_nxt;
    end
  end

  assign clk_out      = r_clk;
  assign tick         = r_tick;
  assign neuron_cnt   = r_cnt;
  assign neuron_idx   = r_cnt[CW-1:SLOT_W];
  assign frame_strobe = r_frame_strobe;
  assign tap_strobe   = r_tap;
  assign frame_cnt    = r_frames;
  assign busy         = (r_state == S_RUN);
  assign done         = r_done;

endmodule

// File: tb/tb_gen_tick_frame.sv
// Bench for gen_tick_frame: directed phases then random stimulus, every cycle
// compared against a counting model built from the tick/frame rules.
`timescale 1ns/1ps
module tb_gen_tick_frame;

  localparam int NN     = 2;
  localparam int SLOT_W = 2;
  localparam int NTAP   = 3;
  localparam int FCW    = 4;
  localparam int NCNT   = 1 << (NN + SLOT_W + 1);
  localparam int TPN    = 1 << SLOT_W;
  localparam int NFR    = 1 << FCW;

  logic        rawclk = 1'b0;
  logic        resetN;
  logic [31:0] halfCnt;
  logic        enable, mode, start;
  logic [8:0]  tapIdx;

  logic        clkOut, tick, frameStrobe, busy, done;
  logic [4:0]  neuronCnt;
  logic [2:0]  neuronIdx, tapStrobe;
  logic [3:0]  frameCnt;

  int nCompared = 0;
  int nMismatch = 0;

  int unsigned mDelay;
  bit          mClk, mRun, mOneShot, mPend;
  int          mCnt, mFrames;
  bit          eTick, eFrame, eDone;
  logic [2:0]  eTap;

  gen_tick_frame #(.NN(NN), .SLOT_W(SLOT_W), .NTAP(NTAP), .FCW(FCW)) dut (
    .rawclk(rawclk), .reset_n(resetN), .half_cnt(halfCnt), .enable(enable),
    .mode(mode), .start(start), .tap_idx(tapIdx), .clk_out(clkOut), .tick(tick),
    .neuron_cnt(neuronCnt), .neuron_idx(neuronIdx), .frame_strobe(frameStrobe),
    .tap_strobe(tapStrobe), .frame_cnt(frameCnt), .busy(busy), .done(done)
  );

  always #5 rawclk = ~rawclk;

  function automatic void modelReset();
    mDelay = 0; mClk = 0; mRun = 0; mOneShot = 0; mPend = 0;
    mCnt = 0; mFrames = 0; eTick = 0; eFrame = 0; eDone = 0; eTap = '0;
  endfunction

  function automatic void modelStrobes(int c);
    eFrame = (c == 0);
    for (int i = 0; i < NTAP; i++)
      eTap[i] = ((c / TPN) == int'(tapIdx[i*3 +: 3])) && ((c % TPN) == 0);
  endfunction

  // One rawclk edge of the reference: rise detection, then run/idle rules.
  function automatic void modelStep();
    bit rise, oldRun, oldPend;
    rise    = (mDelay >= halfCnt) && !mClk;
    oldRun  = mRun;
    oldPend = mPend;
    eTick = rise; eFrame = 0; eTap = '0; eDone = 0;
    if (mDelay >= halfCnt) begin
      mDelay = 0;
      mClk   = !mClk;
    end else begin
      mDelay++;
    end
    if (start && !oldRun) mPend = 1;
    if (rise) begin
      if (oldRun) begin
        modelStrobes(mCnt);
        if (mCnt == NCNT - 1) mFrames = (mFrames + 1) % NFR;
        if (mOneShot) begin
          if (mCnt == NCNT - 1) begin
            eDone = 1;
            mRun  = 0;
          end
        end else if (!enable) begin
          mRun = 0;
        end
        mCnt = (mCnt + 1) % NCNT;
      end else if (!mode) begin
        if (enable) begin
          mRun = 1;
          mOneShot = 0;
        end
      end else if (oldPend) begin
        modelStrobes(0);
        mCnt = 1; mRun = 1; mOneShot = 1; mPend = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    assert (obs === expv) else begin
      nMismatch++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic waitOk(input string tag, input bit ok);
    nCompared++;
    assert (ok) else begin
      nMismatch++;
      $error("[TB] FAIL %s observed=timeout expected=reached", tag);
    end
  endtask

  task automatic checkOutput();
    chk("clk_out",      32'(clkOut),      32'(mClk));
    chk("tick",         32'(tick),        32'(eTick));
    chk("neuron_cnt",   32'(neuronCnt),   32'(mCnt));
    chk("neuron_idx",   32'(neuronIdx),   32'(mCnt / TPN));
    chk("frame_strobe", 32'(frameStrobe), 32'(eFrame));
    chk("tap_strobe",   32'(tapStrobe),   32'(eTap));
    chk("frame_cnt",    32'(frameCnt),    32'(mFrames));
    chk("busy",         32'(busy),        32'(mRun));
    chk("done",         32'(done),        32'(eDone));
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge rawclk);
      if (resetN) modelStep();
      #1;
      checkOutput();
    end
  endtask

  initial begin
    int framesBefore;
    resetN = 0; halfCnt = 32'd3; enable = 0; mode = 0; start = 0;
    tapIdx = {3'd5, 3'd2, 3'd0};
    modelReset();
    applyStimulus(3);
    #3 resetN = 1;

    $display("[TB] free run, period 8");
    enable = 1;
    applyStimulus(800);

    tapIdx = {3'd2, 3'd2, 3'd2};
    applyStimulus(272);
    tapIdx = {3'd5, 3'd2, 3'd0};

    $display("[TB] pause and resume");
    for (int k = 0; k < 400 && !(mRun && mCnt == 12); k++) applyStimulus(1);
    waitOk("pause_reach", mRun && mCnt == 12);
    enable = 0;
    applyStimulus(40);
    chk("pause_hold_cnt", 32'(neuronCnt), 32'd13);
    chk("pause_busy", 32'(busy), 32'd0);
    enable = 1;
    for (int k = 0; k < 100 && mCnt != 14; k++) applyStimulus(1);
    waitOk("resume_reach", mCnt == 14);
    chk("resume_cnt", 32'(neuronCnt), 32'd14);

    $display("[TB] divider changes");
    halfCnt = 32'd0;
    applyStimulus(100);
    halfCnt = 32'd100;
    for (int k = 0; k < 300 && mDelay != 50; k++) applyStimulus(1);
    waitOk("delay_reach", mDelay == 50);
    halfCnt = 32'd2;
    applyStimulus(12);
    halfCnt = 32'd3;

    $display("[TB] one-shot frame");
    enable = 0;
    for (int k = 0; k < 2000 && mRun; k++) applyStimulus(1);
    waitOk("idle_reach", !mRun);
    mode = 1;
    applyStimulus(5);
    framesBefore = mFrames;
    start = 1; applyStimulus(1); start = 0;
    for (int k = 0; k < 50 && !mRun; k++) applyStimulus(1);
    waitOk("os_launch", mRun);
    applyStimulus(40);
    start = 1; applyStimulus(1); start = 0;
    for (int k = 0; k < 400 && !eDone; k++) applyStimulus(1);
    waitOk("os_done", eDone);
    chk("os_frames", 32'(frameCnt), 32'((framesBefore + 1) % NFR));
    applyStimulus(50);
    chk("os_idle_busy", 32'(busy), 32'd0);
    chk("os_idle_cnt", 32'(neuronCnt), 32'd0);

    $display("[TB] async reset mid-frame");
    mode = 0; enable = 1;
    applyStimulus(100);
    #2 resetN = 0;
    modelReset();
    #1 checkOutput();
    #3 resetN = 1;
    applyStimulus(60);

    $display("[TB] random phase");
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      if ($urandom_range(0, 499) == 0) halfCnt = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) tapIdx = 9'($urandom_range(0, 511));
      start = ($urandom_range(0, 49) == 0);
      applyStimulus(1);
    end
    start = 0;
    applyStimulus(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/gen_tick_frame.md
Name: gen_tick_frame

Overview:
- Parametrised successor to the neuron-array clock generator.
- Divides rawclk by a programmable half-period and walks a neuron/slot counter in the same domain.
- Emits single-rawclk-cycle strobes (tick, frame, NTAP programmable taps) that downstream logic uses as clock enables; it generates no derived clocks.
- Adds free-run/one-shot modes, an enable, a frame counter and a busy/done handshake for the host.

Parameters:
- NN, 8: neuron index width is NN+1 bits, giving 2^(NN+1) neurons.
- SLOT_W, 2: slot bits per neuron, giving 2^SLOT_W ticks per neuron.
- NTAP, 3: number of programmable tap strobes.
- FCW, 16: frame counter width.

Ports:
- rawclk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- half_cnt  in  32  divider half-period minus 1.
- enable  in  1  free-run gate; sampled on tick cycles.
- mode  in  1  0 = free-run, 1 = one-shot frame.
- start  in  1  one-shot trigger; single-cycle pulse.
- tap_idx  in  NTAP*(NN+1)  packed neuron indices; tap i occupies bits [i*(NN+1) +: NN+1].
- clk_out  out  1  divided clock level, for observation only.
- tick  out  1  one-cycle pulse on each clk_out rise.
- neuron_cnt  out  NN+SLOT_W+1  full counter.
- neuron_idx  out  NN+1  neuron_cnt[NN+SLOT_W:SLOT_W].
- frame_strobe  out  1  one-cycle pulse at frame start.
- tap_strobe  out  NTAP  one-cycle pulse per tap.
- frame_cnt  out  FCW  completed frames.
- busy  out  1  counter running.
- done  out  1  one-cycle pulse at end of a one-shot frame.

Behaviour:
- Reset: while reset_n=0, every register and output is 0 (clk_out, tick, counters, strobes, busy, done); FSM is IDLE.
- Divider:
  - delay_cnt increments each rawclk.
  - When delay_cnt >= half_cnt: clk_out toggles and delay_cnt <= 0.
  - half_cnt changes take effect immediately; the >= compare guarantees no wrap when half_cnt shrinks.
  - clk_out period = 2*(half_cnt+1) rawclk cycles.
  - The divider runs whenever reset_n=1, independent of mode and enable.
- Rise event: the rawclk edge at which clk_out goes 0->1. tick is registered high for exactly the cycle after that edge.
- FSM states:
  - IDLE (busy=0) and RUN (busy=1).
  - Free mode: IDLE->RUN at a rise event with enable=1; RUN->IDLE at a rise event with enable=0. neuron_cnt holds its value in IDLE (pause, no clear).
  - One-shot mode: start in any cycle sets start_pend. At the next rise event with start_pend set: neuron_cnt <= 1, strobes are evaluated for count 0, and IDLE->RUN.
  - One-shot end: in RUN, the rise event where neuron_cnt = all-ones sets neuron_cnt <= 0 and moves to IDLE. done and the frame_cnt increment occur on that edge.
  - start while busy is ignored, and start_pend is not set.
  - mode changes are honoured only in IDLE; mode is latched on IDLE->RUN.
- Counter: at a rise event in RUN, neuron_cnt <= neuron_cnt+1 with natural wrap. A wrap increments frame_cnt, which itself wraps modulo 2^FCW.
- Strobes: registered at a rise event in RUN (or at the one-shot launch edge) and evaluated on the pre-increment count c.
  - frame_strobe = (c == 0).
  - tap_strobe[i] = (c[NN+SLOT_W:SLOT_W] == tap_idx[i]) && (c[SLOT_W-1:0] == 0).
  - Each strobe is high one rawclk cycle, coincident with tick.
  - No strobes fire in IDLE; tick still pulses.
- Simultaneous events:
  - Several taps programmed to the same index all fire together.
  - A tap at index 0 fires together with frame_strobe.
  - In free mode, enable dropping at the wrap edge still counts the wrap and fires done=0; done is one-shot only.
- Reset mid-operation: async clear of everything; after release, clk_out first rises half_cnt+1 cycles later.

Test Plan:
- Divider: half_cnt=3, reset released -> clk_out period 8, tick pulse every 8 rawclk; half_cnt=0 -> tick every 2 rawclk; switch half_cnt 100->2 with delay_cnt=50 -> toggle on next cycle, no wrap.
- Frame: NN=2, SLOT_W=2, free mode, enable=1 -> frame_strobe every 32 ticks; frame_cnt reads 3 after 96 ticks; neuron_idx steps 0..7, each held for 4 ticks.
- Taps: tap_idx={3'd5,3'd2,3'd0} -> tap_strobe[0] with frame_strobe, tap_strobe[1] at tick 8, tap_strobe[2] at tick 20 of each frame; all three set to 2 -> tap_strobe=3'b111 at tick 8.
- One-shot: mode=1, start pulse -> busy high from next rise; exactly 32 ticks with strobes; done pulse; neuron_cnt=0, frame_cnt+1, busy=0; second start during busy -> no effect.
- Pause: free run, enable=0 at count 13 -> busy=0, neuron_cnt holds 13, no strobes; enable=1 -> resumes at 14.
- Async reset: assert reset_n=0 mid-frame between rawclk edges -> all outputs 0 immediately; release -> restart from count 0, first tick after half_cnt+1 cycles.
